// File: rtl/interleaved_modmul_if.sv
// Operand/status bundle for interleaved_modmul.
// The master drives start and the operands; the slave returns busy, done, result and err.
interface interleaved_modmul_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, a, b, n,
        input  busy, done, result, err
    );

    modport slave (
        input  start, a, b, n,
        output busy, done, result, err
    );
endinterface

// File: rtl/interleaved_modmul.sv
// Radix-2 interleaved modular multiplier, (a*b) mod n, one multiplier bit per cycle, MSB first.
// Define MODMUL_INPUT_CHECK_EN to flag out-of-range operands (n==0, a>=n, b>=n) on err.
module interleaved_modmul #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    interleaved_modmul_if.slave  bus_io
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam int unsigned AccW = WIDTH + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  n_q;
    logic [AccW-1:0]   p_q;
    logic [CntW-1:0]   cnt_q;

    logic [AccW-1:0]   a_ext;
    logic [AccW-1:0]   n_ext;
    logic [AccW-1:0]   p_add;
    logic [AccW-1:0]   p_sub;
    logic [AccW-1:0]   p_d;

    // Two extra accumulator bits keep 2P+a exact while P<n and a<n.
    always_comb begin
        a_ext = {2'b00, a_q};
        n_ext = {2'b00, n_q};
        p_add = (p_q << 1) + (b_q[cnt_q] ? a_ext : '0);
        p_sub = (p_add >= n_ext) ? (p_add - n_ext) : p_add;
        p_d   = (p_sub >= n_ext) ? (p_sub - n_ext) : p_sub;
    end

`ifdef MODMUL_INPUT_CHECK_EN
    logic err_q;
    assign bus_io.err = err_q;
`else
    assign bus_io.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
`ifdef MODMUL_INPUT_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        a_q     <= bus_io.a;
                        b_q     <= bus_io.b;
                        n_q     <= bus_io.n;
                        p_q     <= '0;
                        cnt_q   <= CntW'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        state_q <= StRun;
`ifdef MODMUL_INPUT_CHECK_EN
                        err_q   <= (bus_io.n == '0) || (bus_io.a >= bus_io.n) ||
                                   (bus_io.b >= bus_io.n);
`endif
                    end
                end
                StRun: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q   <= 1'b1;
                    result_q <= p_q[WIDTH-1:0];
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.busy   = busy_q;
    assign bus_io.done   = done_q;
    assign bus_io.result = result_q;

endmodule

// File: doc/interleaved_modmul.md
INTERLEAVED_MODMUL -- requirements
Module: interleaved_modmul

Interface
REQ-001 Parameter: WIDTH, default 16, operand/modulus/result width in bits (legal range 4..64).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 a  input  WIDTH  multiplicand, captured on the accepted start.
REQ-006 b  input  WIDTH  multiplier, captured on the accepted start and scanned MSB first.
REQ-007 n  input  WIDTH  modulus, captured on the accepted start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  single-cycle pulse; result is valid in that cycle.
REQ-010 result  output  WIDTH  (a*b) mod n; held from the done cycle until the next accepted start.
REQ-011 err  output  1  input-range violation flag; see Configuration.

Function
REQ-012 Algorithm SHALL be radix-2 interleaved: P=0; for i=WIDTH-1 downto 0: P=2P; if b[i] then P=P+a; if P>=n then P=P-n; if P>=n then P=P-n.
REQ-013 The internal accumulator SHALL be WIDTH+2 bits so that 2P+a never overflows for a<n, P<n.
REQ-014 One loop iteration (shift, add, up to two conditional subtracts) SHALL complete per clock cycle.
REQ-015 States SHALL be IDLE, RUN and DONE.
REQ-016 IDLE -> RUN when start=1: capture a, b, n, clear P, and load the bit counter with WIDTH-1.
REQ-017 RUN SHALL process bit b[counter] each cycle and decrement the counter; RUN -> DONE after the cycle that processes bit 0 (exactly WIDTH RUN cycles).
REQ-018 DONE SHALL drive done=1, update result with P[WIDTH-1:0], and go to IDLE on the next cycle.
REQ-019 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH+1.
REQ-020 Back-to-back operation: start asserted in the cycle after done SHALL be accepted; throughput is one result per WIDTH+2 cycles.
REQ-021 start asserted in RUN or DONE SHALL be ignored; captured operands SHALL NOT change.
REQ-022 Changes on a, b or n after capture SHALL NOT affect the running operation.
REQ-023 Correct results require n>0, a<n and b<n; outside that range result is unspecified but the FSM SHALL still finish in WIDTH+2 cycles.
REQ-024 b=0 or a=0 SHALL yield result=0; n=1 SHALL yield result=0.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, busy=0, done=0, result=0, err=0, P=0, counter=0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation, produce no done pulse, and take priority over start.
REQ-027 The first start after reset is released SHALL be accepted normally.

Configuration
REQ-028 Macro MODMUL_INPUT_CHECK_EN defined: on an accepted start, err SHALL be set when n==0, a>=n or b>=n; the operation still runs; err holds until the next accepted start or reset.
REQ-029 Macro MODMUL_INPUT_CHECK_EN undefined: no range-checking comparators are built and err SHALL be tied to 0.

Verification
REQ-030 WIDTH=16, a=3, b=5, n=7, start for 1 cycle -> busy for 17 cycles, done pulse 17 cycles after the start edge, result=1.
REQ-031 WIDTH=16, a=65520, b=65520, n=65521 -> result=1; a=12345, b=0, n=65521 -> result=0.
REQ-032 start held high continuously with a=10, b=20, n=97 -> a new operation begins every 18 cycles, and each result is 6.
REQ-033 start issued mid-RUN with different operands -> ignored; result matches the first operands; no additional done pulse.
REQ-034 rst asserted during cycle 8 of RUN -> no done pulse, all outputs 0; a following start with a=2, b=3, n=5 -> result=1.
REQ-035 With MODMUL_INPUT_CHECK_EN defined, a=9, b=2, n=7 -> err=1 from the cycle after start; without the macro -> err=0 throughout.
